// File: rtl/enfasi_pkg.sv
// ---------------------------------------------------------------------------
// enfasi_pkg
//   Shared constants, state encoding and sample types for the de-emphasis
//   receive path.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package enfasi_pkg;

  localparam int WI     = 12;   // input sample width, signed Q1.10
  localparam int WO     = 11;   // output sample width, signed Q0.10
  localparam int FRAC   = 10;   // fractional bits of samples and coefficient
  localparam int CW     = 11;   // coefficient width, unsigned
  localparam int A_COEF = 960;  // 0.9375 in unsigned Q0.10

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } deenf_state_t;

  typedef logic signed [WI-1:0] q_t;
  typedef logic signed [WO-1:0] y_t;

endpackage

`default_nettype wire

// File: rtl/mul_seriale.sv
// ---------------------------------------------------------------------------
// mul_seriale
//   Serial shift-add multiplier, signed multiplicand x unsigned multiplier,
//   one multiplier bit per cycle (LSB first).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_seriale
  import enfasi_pkg::*;
#(
  parameter int WA = WO,
  parameter int WB = CW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WA-1:0]    a,
  input  logic        [WB-1:0]    b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WA+WB-1:0] product
);

  localparam int WP   = WA + WB;
  localparam int CNTW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(WB - 1);

  logic                   busy_q,  busy_d;
  logic        [CNTW-1:0] cnt_q,   cnt_d;
  logic signed [WP-1:0]   mcand_q, mcand_d;
  logic        [WB-1:0]   coef_q,  coef_d;
  logic signed [WP-1:0]   acc_q,   acc_d;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = {{WB{a[WA-1]}}, a};
      coef_d  = b;
      acc_d   = '0;
    end else if (busy_q) begin
      // Multiplicand shifts left while the multiplier shifts right, so bit k
      // of the coefficient always meets a<<k.
      if (coef_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q <<< 1;
      coef_d  = coef_q >> 1;
      cnt_d   = cnt_q + CNTW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      coef_q  <= '0;
      acc_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/deenfasi.sv
// ---------------------------------------------------------------------------
// deenfasi
//   De-emphasis IIR y[n] = conv(q[n] + round(A*y[n-1])), valid/ready on both
//   sides, one sample in flight. Optional macro DEENFASI_SAT_EN selects
//   clamping with sticky ovf; otherwise the sum wraps and ovf is 0.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module deenfasi
  import enfasi_pkg::*;
#(
  parameter logic [CW-1:0] COEF = CW'(A_COEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WI-1:0] q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WO-1:0] y,
  output logic                 ovf
);

  localparam int WP = WO + CW;
  localparam logic signed [WP-1:0] HALF = WP'(1) <<< (FRAC - 1);

  deenf_state_t state_q, state_d;
  q_t           q_lat_q, q_lat_d;
  y_t           y_q,     y_d;     // also serves as y_prev for the feedback

  logic                   mul_start;
  logic                   mul_busy;
  logic                   mul_done;
  logic signed [WP-1:0]   mul_prod;

  logic signed [WP-1:0]      rnd_full;
  logic signed [WP-FRAC-1:0] rounded;
  logic signed [WI:0]        q_ext;
  logic signed [WI:0]        rnd_ext;
  logic signed [WI:0]        sum;
  y_t                        y_next;
  logic                      y_clamp;
  logic                      unused_bits;

  mul_seriale #(
    .WA (WO),
    .WB (CW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (y_q),
    .b       (COEF),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Round half toward +inf, then drop the fractional bits of the coefficient.
  always_comb begin
    rnd_full = mul_prod + HALF;
    rounded  = rnd_full[WP-1:FRAC];
    q_ext    = q_lat_q;
    rnd_ext  = rounded;
    sum      = q_ext + rnd_ext;
  end

`ifdef DEENFASI_SAT_EN
  localparam logic signed [WI:0] Y_MAX = {{(WI+2-WO){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WI:0] Y_MIN = {{(WI+2-WO){1'b1}}, {(WO-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_comb begin
    y_next  = sum[WO-1:0];
    y_clamp = 1'b0;
    if (sum > Y_MAX) begin
      y_next  = Y_MAX[WO-1:0];
      y_clamp = 1'b1;
    end else if (sum < Y_MIN) begin
      y_next  = Y_MIN[WO-1:0];
      y_clamp = 1'b1;
    end
  end

  assign unused_bits = ^{rnd_full[FRAC-1:0], mul_busy};
  assign ovf         = ovf_q;
`else
  always_comb begin
    y_next  = sum[WO-1:0];
    y_clamp = 1'b0;
  end

  assign unused_bits = ^{rnd_full[FRAC-1:0], mul_busy, sum[WI:WO], y_clamp};
  assign ovf         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    q_lat_d   = q_lat_q;
    y_d       = y_q;
    mul_start = 1'b0;
`ifdef DEENFASI_SAT_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_lat_d   = q;
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = ADD;
        end
      end
      ADD: begin
        y_d     = y_next;
`ifdef DEENFASI_SAT_EN
        if (y_clamp) begin
          ovf_d = 1'b1;
        end
`endif
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_lat_q <= '0;
      y_q     <= '0;
`ifdef DEENFASI_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_lat_q <= q_lat_d;
      y_q     <= y_d;
`ifdef DEENFASI_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign y         = y_q;

endmodule

`default_nettype wire

// File: tb/tb_deenfasi.sv
// ---------------------------------------------------------------------------
// tb_deenfasi
//   Directed self-checking bench for the de-emphasis filter.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_deenfasi;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] q_s;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] y;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  deenfasi dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_sample(input int qv, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    q_s      = 12'(qv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q_s      = '0;
  endtask

  // Latency counts edges after the handshake edge until the edge that
  // samples out_valid high (13 = CW+2).
  task automatic wait_out(input int ey, input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_lat"}, lat, 13);
    chk({tag, "_y"}, y, ey);
  endtask

  task automatic do_sample(input int qv, input int ey, input string tag);
    start_sample(qv, tag);
    wait_out(ey, tag);
    @(posedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q_s       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Positive impulse
    do_sample(512, 512, "imp0");
    do_sample(0, 480, "imp1");
    do_sample(0, 450, "imp2");
    do_sample(0, 422, "imp3");
    chk("imp_ovf", ovf, 0);

    // Negative impulse: rounding of negative products
    reset_pulse();
    do_sample(-512, -512, "neg0");
    do_sample(0, -480, "neg1");
    do_sample(0, -450, "neg2");
    do_sample(0, -422, "neg3");

    // Saturation / wrap
    reset_pulse();
    do_sample(512, 512, "sat0");
    do_sample(512, 992, "sat1");
`ifdef DEENFASI_SAT_EN
    do_sample(512, 1023, "sat2");
    chk("sat_ovf", ovf, 1);
`else
    do_sample(512, -606, "sat2");
    chk("sat_ovf", ovf, 0);
`endif
    reset_pulse();
    chk("ovf_cleared", ovf, 0);

    // Backpressure: OUT held, in_valid must be ignored
    out_ready = 1'b0;
    start_sample(512, "bp");
    wait_out(512, "bp");
    in_valid = 1'b1;
    q_s      = 12'(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_y_hold", y, 512);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    q_s       = '0;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("bp_single_xfer", n, 0);

    // Reset four clocks into MUL aborts the sample and clears y_prev (512)
    start_sample(512, "abort");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_y", y, 0);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_output", n, 0);
    do_sample(512, 512, "post_abort");
    chk("final_ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
